// File: rtl/mdu_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer: shift-add multiply, restoring divide,
// pipeline stall handshake and a one-cycle HI/LO write strobe.
module mdu_sequencer #(
  parameter int WIDTH      = 32,
  parameter int DIV_CYCLES = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               startE,
  input  logic [1:0]         opE,
  input  logic [WIDTH-1:0]   srcaE,
  input  logic [WIDTH-1:0]   srcbE,
  input  logic               cancelE,
  output logic               stall_mdu,
  output logic               hilo_we,
  output logic [WIDTH-1:0]   hi_o,
  output logic [WIDTH-1:0]   lo_o,
  output logic               busy
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;        // |multiplicand| or |dividend|
  logic [WIDTH-1:0] b_q, b_d;        // |multiplier|   or |divisor|
  logic [WIDTH-1:0] hw_q, hw_d;      // product high / partial remainder
  logic [WIDTH-1:0] lw_q, lw_d;      // multiplier shifting out / quotient shifting in
  logic [WIDTH-1:0] araw_q, araw_d;  // raw dividend, returned in HI on divide-by-zero
  logic             neg_q, neg_d;
  logic             sign_a_q, sign_a_d;
  logic             div0_q, div0_d;
  logic             is_div_q, is_div_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             sgn, sa, sb;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0] res_hi, res_lo;

  assign sgn   = ~opE[0];
  assign sa    = sgn & srcaE[WIDTH-1];
  assign sb    = sgn & srcbE[WIDTH-1];
  assign abs_a = sa ? (~srcaE + 1'b1) : srcaE;
  assign abs_b = sb ? (~srcbE + 1'b1) : srcbE;

  assign mul_sum   = {1'b0, hw_q} + {1'b0, a_q & {WIDTH{lw_q[0]}}};
  assign div_shift = {hw_q, lw_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, b_q};

  // Sign fix-up of the unsigned iteration result, valid while in DONE.
  always_comb begin
    prod   = {hw_q, lw_q};
    prod_s = neg_q ? (~prod + 1'b1) : prod;
    res_hi = prod_s[2*WIDTH-1:WIDTH];
    res_lo = prod_s[WIDTH-1:0];
    if (is_div_q) begin
      if (div0_q) begin
        res_hi = araw_q;
        res_lo = '1;
      end else begin
        res_hi = sign_a_q ? (~hw_q + 1'b1) : hw_q;
        res_lo = neg_q    ? (~lw_q + 1'b1) : lw_q;
      end
    end
  end

  // NOTE: every next-state signal gets a default first so no path leaves one unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    hw_d     = hw_q;
    lw_d     = lw_q;
    araw_d   = araw_q;
    neg_d    = neg_q;
    sign_a_d = sign_a_q;
    div0_d   = div0_q;
    is_div_d = is_div_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    unique case (state_q)
      IDLE: begin
        if (startE && !cancelE) begin
          a_d      = abs_a;
          b_d      = abs_b;
          hw_d     = '0;
          lw_d     = opE[1] ? abs_a : abs_b;
          araw_d   = srcaE;
          neg_d    = sa ^ sb;
          sign_a_d = sa;
          div0_d   = opE[1] && (srcbE == '0);
          is_div_d = opE[1];
          cnt_d    = '0;
          state_d  = opE[1] ? DIV : MUL;
        end
      end
      MUL: begin
        if (cancelE) begin
          state_d = IDLE;
        end else begin
          hw_d = mul_sum[WIDTH:1];
          lw_d = {mul_sum[0], lw_q[WIDTH-1:1]};
          if (cnt_q == CW'(WIDTH - 1)) state_d = DONE;
          else                         cnt_d   = cnt_q + CW'(1);
        end
      end
      DIV: begin
        if (cancelE) begin
          state_d = IDLE;
        end else begin
          hw_d = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
          lw_d = {lw_q[WIDTH-2:0], ~div_diff[WIDTH]};
          if (cnt_q == CW'(DIV_CYCLES - 1)) state_d = DONE;
          else                              cnt_d   = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        if (!cancelE) begin
          hi_d = res_hi;
          lo_d = res_lo;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      hw_q     <= '0;
      lw_q     <= '0;
      araw_q   <= '0;
      neg_q    <= 1'b0;
      sign_a_q <= 1'b0;
      div0_q   <= 1'b0;
      is_div_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      hw_q     <= hw_d;
      lw_q     <= lw_d;
      araw_q   <= araw_d;
      neg_q    <= neg_d;
      sign_a_q <= sign_a_d;
      div0_q   <= div0_d;
      is_div_q <= is_div_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  // The result is visible during DONE itself and committed to hi_q/lo_q on its edge.
  assign hilo_we   = (state_q == DONE) && !cancelE;
  assign hi_o      = hilo_we ? res_hi : hi_q;
  assign lo_o      = hilo_we ? res_lo : lo_q;
  assign stall_mdu = startE && !cancelE && (state_q != DONE);
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed bench for mdu_sequencer: scoreboard of expected HI/LO pushed at issue,
// popped at the write strobe, plus latency, stall, cancel and reset checks.
module tb_mdu_sequencer;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          startE;
  logic [1:0]    opE;
  logic [W-1:0]  srcaE;
  logic [W-1:0]  srcbE;
  logic          cancelE;
  logic          stall_mdu;
  logic          hilo_we;
  logic [W-1:0]  hi_o;
  logic [W-1:0]  lo_o;
  logic          busy;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } exp_t;

  exp_t         sb_q[$];
  int           n_cmp = 0;
  int           n_err = 0;
  logic [W-1:0] last_hi = '0;
  logic [W-1:0] last_lo = '0;

  mdu_sequencer #(.WIDTH(W), .DIV_CYCLES(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .startE    (startE),
    .opE       (opE),
    .srcaE     (srcaE),
    .srcbE     (srcbE),
    .cancelE   (cancelE),
    .stall_mdu (stall_mdu),
    .hilo_we   (hilo_we),
    .hi_o      (hi_o),
    .lo_o      (lo_o),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL timeout: observed=no finish required=finish");
    $fatal(1, "bench timed out");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference arithmetic with 64-bit integers; returns {HI, LO}.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                        input logic [W-1:0] b);
    longint          sa, sbv, q, r;
    longint unsigned ua, ub;
    logic [63:0]     p;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    p   = '0;
    case (op)
      2'b00: p = sa * sbv;
      2'b01: p = ua * ub;
      default: begin
        if (b == '0) begin
          p = {a, 32'hFFFF_FFFF};
        end else if (op == 2'b10) begin
          q = sa / sbv;
          r = sa % sbv;
          p = {r[31:0], q[31:0]};
        end else begin
          q = longint'(ua / ub);
          r = longint'(ua % ub);
          p = {r[31:0], q[31:0]};
        end
      end
    endcase
    return p;
  endfunction

  // Issue one op at a negedge, hold startE until the write strobe, check the timing.
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [63:0] exp, input logic drop, input string tag);
    int   c      = 0;
    int   stalls = 0;
    bit   seen   = 0;
    exp_t e;
    e.hi = exp[63:32];
    e.lo = exp[31:0];
    sb_q.push_back(e);
    startE = 1'b1;
    opE    = op;
    srcaE  = a;
    srcbE  = b;
    while (!seen && c < W + 8) begin
      #1;
      if (hilo_we) begin
        seen = 1;
      end else begin
        if (stall_mdu) stalls++;
        @(negedge clk);
        c++;
        if (c == 1) begin
          srcaE = $urandom;
          srcbE = $urandom;
        end
      end
    end
    check({tag, " strobe_seen"}, 64'(seen), 64'd1);
    check({tag, " latency"}, 64'(c), 64'(W + 1));
    check({tag, " stall_cycles"}, 64'(stalls), 64'(W + 1));
    check({tag, " stall_in_done"}, 64'(stall_mdu), 64'd0);
    e = sb_q.pop_front();
    check({tag, " hi"}, 64'(hi_o), 64'(e.hi));
    check({tag, " lo"}, 64'(lo_o), 64'(e.lo));
    last_hi = e.hi;
    last_lo = e.lo;
    @(negedge clk);
    if (drop) startE = 1'b0;
    #1;
    check({tag, " single_strobe"}, 64'(hilo_we), 64'd0);
    check({tag, " idle_after"}, 64'(busy), 64'd0);
    check({tag, " hi_held"}, 64'(hi_o), 64'(last_hi));
    check({tag, " lo_held"}, 64'(lo_o), 64'(last_lo));
  endtask

  initial begin
    rst     = 1'b1;
    startE  = 1'b0;
    opE     = 2'b00;
    srcaE   = '0;
    srcbE   = '0;
    cancelE = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset busy", 64'(busy), 64'd0);
    check("reset stall", 64'(stall_mdu), 64'd0);
    check("reset we", 64'(hilo_we), 64'd0);
    check("reset hi", 64'(hi_o), 64'd0);
    check("reset lo", 64'(lo_o), 64'd0);
    @(negedge clk);

    run_op(2'b00, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, 1'b1, "mult_neg3x5");
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b1, "multu_max");
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1, "div_neg7by2");
    run_op(2'b11, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 1'b1, "divu_100by7");
    run_op(2'b11, 32'h0000_1234, 32'd0, 64'h0000_1234_FFFF_FFFF, 1'b1, "divu_by0");
    run_op(2'b10, 32'd7, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 1'b1, "div_7bymin2");
    run_op(2'b10, 32'hFFFF_FFF8, 32'd0, 64'hFFFF_FFF8_FFFF_FFFF, 1'b1, "div_neg_by0");
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, model(2'b10, 32'h8000_0000, 32'hFFFF_FFFF),
           1'b1, "div_minint");
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, model(2'b00, 32'h8000_0000, 32'h8000_0000),
           1'b1, "mult_minint");
    for (int i = 0; i < 4; i++) begin
      logic [1:0]   rop;
      logic [W-1:0] ra, rb;
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      run_op(rop, ra, rb, model(rop, ra, rb), 1'b1, "random");
    end

    // Cancel during DIV: no write, HI/LO keep the previous result.
    startE = 1'b1;
    opE    = 2'b10;
    srcaE  = 32'd1000;
    srcbE  = 32'd3;
    repeat (10) @(negedge clk);
    cancelE = 1'b1;
    #1;
    check("cancel stall", 64'(stall_mdu), 64'd0);
    check("cancel we", 64'(hilo_we), 64'd0);
    @(negedge clk);
    startE  = 1'b0;
    cancelE = 1'b0;
    #1;
    check("cancel idle", 64'(busy), 64'd0);
    check("cancel hi_kept", 64'(hi_o), 64'(last_hi));
    check("cancel lo_kept", 64'(lo_o), 64'(last_lo));
    repeat (2) @(negedge clk);
    run_op(2'b00, 32'd12, 32'hFFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFE8, 1'b1, "mult_after_cancel");

    // cancelE wins over startE in IDLE.
    startE  = 1'b1;
    cancelE = 1'b1;
    opE     = 2'b01;
    #1;
    check("idle_cancel stall", 64'(stall_mdu), 64'd0);
    @(negedge clk);
    startE  = 1'b0;
    cancelE = 1'b0;
    #1;
    check("idle_cancel busy", 64'(busy), 64'd0);
    @(negedge clk);

    // Back-to-back: DIV then MULT with startE never dropping in between.
    run_op(2'b10, 32'hFFFF_FF9C, 32'd7, 64'hFFFF_FFFE_FFFF_FFF2, 1'b0, "b2b_div");
    run_op(2'b00, 32'd3, 32'd4, 64'h0000_0000_0000_000C, 1'b1, "b2b_mult");

    // Reset mid-MULT clears everything with no write.
    startE = 1'b1;
    opE    = 2'b00;
    srcaE  = 32'd9;
    srcbE  = 32'd9;
    repeat (5) @(negedge clk);
    rst    = 1'b1;
    startE = 1'b0;
    @(negedge clk);
    #1;
    check("midrst busy", 64'(busy), 64'd0);
    check("midrst stall", 64'(stall_mdu), 64'd0);
    check("midrst we", 64'(hilo_we), 64'd0);
    check("midrst hi", 64'(hi_o), 64'd0);
    check("midrst lo", 64'(lo_o), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    run_op(2'b11, 32'd50, 32'd8, 64'h0000_0002_0000_0006, 1'b1, "divu_after_rst");

    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mdu_sequencer.md
Name: mdu_sequencer

Overview:
- Multi-cycle multiply/divide sequencer for the 5-stage MIPS pipeline.
- Accepts MULT/MULTU/DIV/DIVU from the execute stage and stalls the pipeline while the operation runs.
- Produces the 64-bit HI/LO result with a one-cycle HI/LO write strobe, which feeds the HI/LO write path alongside HiLoWriteE.
- Owns the arithmetic iteration (shift-add multiply, restoring divide) and the handshake with the hazard unit.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits
DIV_CYCLES, 32, divide iteration count; must equal WIDTH

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
startE  in  1  MDU instruction valid in execute stage; held high while the pipeline is stalled
opE  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
srcaE  in  WIDTH  rs operand (multiplicand / dividend)
srcbE  in  WIDTH  rt operand (multiplier / divisor)
cancelE  in  1  flush of execute stage (exception/branch); aborts the operation
stall_mdu  out  1  to hazard unit; freezes F/D/E while high
hilo_we  out  1  one-cycle HI/LO write strobe
hi_o  out  WIDTH  HI result (remainder / product high)
lo_o  out  WIDTH  LO result (quotient / product low)
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (rst=1 at clock edge): state=IDLE. Outputs stall_mdu=0, hilo_we=0, busy=0, hi_o=0, lo_o=0. Internal registers cleared. Reset mid-operation abandons the operation with no write.
- States: IDLE, MUL, DIV, DONE.
- IDLE: startE=1 & cancelE=0 latches operands and op.
  - Signed ops: latch absolute values and result sign bits.
  - op[1]=0 -> MUL, cnt=0.
  - op[1]=1 -> DIV, cnt=0.
- MUL: shift-add, 1 multiplier bit per cycle for WIDTH cycles, then DONE.
  - Signed result = two's-complement negate of unsigned product when sign_a^sign_b.
- DIV: restoring divide, 1 quotient bit per cycle for DIV_CYCLES cycles, then DONE.
  - Signed: quotient negated if sign_a^sign_b; remainder takes the sign of the dividend.
  - MIPS truncation semantics: -7/2 gives q=-3, r=-1.
- Divisor zero: result fixed at HI=dividend (raw srcaE), LO={WIDTH{1}}. The full iteration latency is still taken.
- DONE: hilo_we=1 for exactly this cycle; hi_o/lo_o valid. Next state IDLE unconditionally.
  - startE seen in DONE is the same instruction still in E and is ignored.
  - A new MDU op is accepted only from IDLE.
- stall_mdu = startE & ~cancelE & (state != DONE), combinational.
  - Start accepted at cycle 0: stall high cycles 0..WIDTH; DONE at cycle WIDTH+1 with stall=0.
  - The instruction leaves E at the end of the DONE cycle.
- hi_o/lo_o hold their last written value outside DONE. Updated only on the DONE edge.
- cancelE=1 in MUL/DIV/DONE: next state IDLE, hilo_we stays 0, HI/LO unchanged, stall_mdu=0 in that cycle.
  - cancelE has priority over startE in IDLE.
- Simultaneous cancelE and rst: rst wins, same outcome.
- Operand changes on srcaE/srcbE after acceptance are ignored (operands latched).
- Counter is log2(WIDTH)+1 bits. Terminal test is cnt==WIDTH-1 in the iterating state; no wrap.

Test Plan:
- MULT srca=0xFFFFFFFD (-3), srcb=5 -> DONE at cycle 33: hi_o=0xFFFFFFFF, lo_o=0xFFFFFFF1, hilo_we high exactly 1 cycle; stall high cycles 0..32.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi_o=0xFFFFFFFE, lo_o=0x00000001.
- DIV 0xFFFFFFF9 (-7) / 2 -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF. DIVU 100/7 -> lo_o=14, hi_o=2.
- DIVU 0x1234 / 0 -> hi_o=0x00001234, lo_o=0xFFFFFFFF after full latency, no X.
- Start DIV, assert cancelE at cycle 10 -> state IDLE next cycle, stall_mdu=0, no hilo_we, HI/LO keep prior values. A new MULT issued 2 cycles later completes normally.
- Start MULT, rst=1 at cycle 5 -> all outputs 0 next cycle. startE held through DONE -> only one hilo_we pulse; back-to-back DIV then MULT each produce one write.
